// File: rtl/alu_pkg.sv
// Shared decode constants, field positions and FSM state type for the ALU
// issue/writeback stage.
package alu_pkg;

   localparam int DW    = 16;
   localparam int NREGS = 8;
   localparam int RW    = 3;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MULT = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_DIV  = 3'd4;
   localparam logic [2:0] OP_MOD  = 3'd5;
   localparam logic [2:0] OP_LT   = 3'd6;
   localparam logic [2:0] OP_LE   = 3'd7;

   localparam int F_LOADI  = 15;
   localparam int F_OP_LO  = 12;
   localparam int F_RD_LO  = 9;
   localparam int F_RS1_LO = 6;
   localparam int F_RS2_LO = 3;
   localparam int F_LRD_LO = 12;
   localparam int F_IMM_W  = 8;

   typedef enum logic {IDLE, EXEC} state_t;

   function automatic logic is_divmod(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Instruction handshake, ALU drive/return, writeback and debug signals of the
// dispatch stage. master = instruction source / ALU side, slave = dispatch.
interface alu_dispatch_if;
   import alu_pkg::*;

   logic [15:0]   instr;
   logic          instr_valid;
   logic          instr_ready;
   logic [2:0]    alu_operator;
   logic [DW-1:0] alu_op1;
   logic [DW-1:0] alu_op2;
   logic [DW-1:0] alu_result;
   logic          done;
   logic [RW-1:0] wb_rd;
   logic [DW-1:0] wb_data;
   logic          div0;
   logic          div0_clr;
   logic [RW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;

   modport master (
      output instr, instr_valid, alu_result, div0_clr, dbg_addr,
      input  instr_ready, alu_operator, alu_op1, alu_op2, done, wb_rd, wb_data,
             div0, dbg_data
   );

   modport slave (
      input  instr, instr_valid, alu_result, div0_clr, dbg_addr,
      output instr_ready, alu_operator, alu_op1, alu_op2, done, wb_rd, wb_data,
             div0, dbg_data
   );

endinterface

// File: rtl/alu_regfile.sv
// 8x16 register file: two operand read ports, one debug read port, one
// synchronous write port; R0 reads as zero and ignores writes.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int NREGS = alu_pkg::NREGS,
   parameter int DW    = alu_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [RW-1:0] ra1,
   input  logic [RW-1:0] ra2,
   input  logic [RW-1:0] rad,
   input  logic          we,
   input  logic [RW-1:0] wa,
   input  logic [DW-1:0] wd,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   output logic [DW-1:0] rdd
);

   logic [DW-1:0] regs [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
   assign rdd = (rad == '0) ? '0 : regs[rad];

endmodule

// File: rtl/alu_dispatch.sv
// Issue/writeback stage in front of the 16-bit ALU: decodes instructions,
// drives registered operands to the ALU and writes its result back.
//
//   state | meaning
//   IDLE  | ready; LOADI retires in place, ALU op latches operands
//   EXEC  | ALU inputs valid; result (or div0 fault) retires at cycle end
module alu_dispatch
   import alu_pkg::*;
#(
   parameter int NREGS = alu_pkg::NREGS,
   parameter int DW    = alu_pkg::DW
) (
   input logic           clk,
   input logic           rst,
   alu_dispatch_if.slave bus
);

   state_t        state_q, state_d;
   logic [DW-1:0] rs1_data, rs2_data;
   logic [RW-1:0] rd_q;
   logic          latch_ops;
   logic          retire;
   logic          div_fault;
   logic          we;
   logic [RW-1:0] wa;
   logic [DW-1:0] wd;
   logic [DW-1:0] imm_ext;
   logic          unused_fields;

   assign imm_ext       = {{(DW-F_IMM_W){1'b0}}, bus.instr[F_IMM_W-1:0]};
   assign unused_fields = ^bus.instr[2:0];

   alu_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (bus.instr[F_RS1_LO +: RW]),
      .ra2 (bus.instr[F_RS2_LO +: RW]),
      .rad (bus.dbg_addr),
      .we  (we),
      .wa  (wa),
      .wd  (wd),
      .rd1 (rs1_data),
      .rd2 (rs2_data),
      .rdd (bus.dbg_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      bus.instr_ready = 1'b0;
      latch_ops       = 1'b0;
      retire          = 1'b0;
      div_fault       = 1'b0;
      we              = 1'b0;
      wa              = rd_q;
      wd              = bus.alu_result;
      case (state_q)
         IDLE: begin
            bus.instr_ready = 1'b1;
            if (bus.instr_valid) begin
               if (bus.instr[F_LOADI]) begin
                  we     = 1'b1;
                  wa     = bus.instr[F_LRD_LO +: RW];
                  wd     = imm_ext;
                  retire = 1'b1;
               end else begin
                  latch_ops = 1'b1;
                  state_d   = EXEC;
               end
            end
         end
         EXEC: begin
            retire  = 1'b1;
            state_d = IDLE;
            // Zero divisor is judged on the operand actually presented to the ALU
            if (is_divmod(bus.alu_operator) && (bus.alu_op2 == '0)) div_fault = 1'b1;
            else                                                    we        = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.alu_operator <= '0;
         bus.alu_op1      <= '0;
         bus.alu_op2      <= '0;
         rd_q             <= '0;
      end else if (latch_ops) begin
         bus.alu_operator <= bus.instr[F_OP_LO +: 3];
         bus.alu_op1      <= rs1_data;
         bus.alu_op2      <= rs2_data;
         rd_q             <= bus.instr[F_RD_LO +: RW];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.done    <= 1'b0;
         bus.wb_rd   <= '0;
         bus.wb_data <= '0;
      end else begin
         bus.done <= retire;
         if (retire) begin
            bus.wb_rd   <= wa;
            bus.wb_data <= (we && (wa != '0)) ? wd : '0;
         end
      end
   end

   // Set has priority over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               bus.div0 <= 1'b0;
      else if (div_fault)    bus.div0 <= 1'b1;
      else if (bus.div0_clr) bus.div0 <= 1'b0;
   end

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed scenarios plus random
// instruction streams against an architectural register/flag model.
module tb_alu_dispatch;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_dispatch_if bus();

   alu_dispatch #(.NREGS(8), .DW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          errors = 0;
   int          checks = 0;
   logic [15:0] mreg [8];
   logic        mdiv0;

   function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return b - a;
         OP_MULT: begin p = a * b; return p[15:0]; end
         OP_NAND: return ~(a & b);
         OP_DIV:  return (b == 0) ? 16'h0 : a / b;
         OP_MOD:  return (b == 0) ? 16'h0 : a % b;
         OP_LT:   return (a < b) ? 16'd1 : 16'd0;
         default: return (a <= b) ? 16'd1 : 16'd0;
      endcase
   endfunction

   always_comb bus.alu_result = alu_ref(bus.alu_operator, bus.alu_op1, bus.alu_op2);

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         bus.dbg_addr = 3'(i);
         #1;
         chk(tag, bus.dbg_data, mreg[i]);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", 16'(bus.instr_ready), 16'd1);
      chk("rst_done", 16'(bus.done), 16'd0);
      chk("rst_operator", 16'(bus.alu_operator), 16'd0);
      chk("rst_op1", bus.alu_op1, 16'd0);
      chk("rst_op2", bus.alu_op2, 16'd0);
      chk("rst_wb_rd", 16'(bus.wb_rd), 16'd0);
      chk("rst_wb_data", bus.wb_data, 16'd0);
      chk("rst_div0", 16'(bus.div0), 16'd0);
   endtask

   // Issue one instruction (entered with the DUT idle, away from a rising edge)
   // and check it through to retirement; returns at the retire-cycle negedge.
   task automatic run(input logic [15:0] ins, input logic clr);
      logic [2:0]  op, rd;
      logic [15:0] a, b, res, exp_wb;
      logic        fault;
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      if (ins[15]) begin
         rd     = ins[14:12];
         exp_wb = (rd == 0) ? 16'h0 : {8'h00, ins[7:0]};
         if (rd != 0) mreg[rd] = exp_wb;
         bus.dbg_addr = rd;
         @(negedge clk);
         chk("li_done", 16'(bus.done), 16'd1);
         chk("li_wb_rd", 16'(bus.wb_rd), 16'(rd));
         chk("li_wb_data", bus.wb_data, exp_wb);
         chk("li_dbg", bus.dbg_data, mreg[rd]);
         chk("li_ready", 16'(bus.instr_ready), 16'd1);
      end else begin
         op = ins[14:12];
         rd = ins[11:9];
         a  = mreg[ins[8:6]];
         b  = mreg[ins[5:3]];
         bus.div0_clr = clr;
         @(negedge clk);
         chk("ex_ready", 16'(bus.instr_ready), 16'd0);
         chk("ex_done", 16'(bus.done), 16'd0);
         chk("ex_operator", 16'(bus.alu_operator), 16'(op));
         chk("ex_op1", bus.alu_op1, a);
         chk("ex_op2", bus.alu_op2, b);
         fault = ((op == OP_DIV) || (op == OP_MOD)) && (b == 0);
         res   = alu_ref(op, a, b);
         if (fault) begin
            exp_wb = 16'h0;
            mdiv0  = 1'b1;
         end else begin
            exp_wb = (rd == 0) ? 16'h0 : res;
            if (rd != 0) mreg[rd] = res;
            if (clr) mdiv0 = 1'b0;
         end
         @(posedge clk); #1;
         bus.div0_clr = 1'b0;
         bus.dbg_addr = rd;
         @(negedge clk);
         chk("wb_done", 16'(bus.done), 16'd1);
         chk("wb_rd", 16'(bus.wb_rd), 16'(rd));
         chk("wb_data", bus.wb_data, exp_wb);
         chk("wb_div0", 16'(bus.div0), 16'(mdiv0));
         chk("wb_dbg", bus.dbg_data, mreg[rd]);
         chk("wb_ready", 16'(bus.instr_ready), 16'd1);
      end
   endtask

   initial begin
      logic [15:0] ia, ib, ra, rb;
      rst             = 1'b1;
      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      bus.div0_clr    = 1'b0;
      bus.dbg_addr    = '0;
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      mdiv0 = 1'b0;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs();
      chk_regs("rst_reg");

      // Back-to-back LOADIs retire on consecutive cycles
      @(posedge clk); #1;
      bus.instr       = 16'h9007;
      bus.instr_valid = 1'b1;
      @(posedge clk); #1;
      bus.instr = 16'hA003;
      @(negedge clk);
      chk("b2b_done1", 16'(bus.done), 16'd1);
      chk("b2b_rd1", 16'(bus.wb_rd), 16'd1);
      chk("b2b_data1", bus.wb_data, 16'h0007);
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("b2b_done2", 16'(bus.done), 16'd1);
      chk("b2b_rd2", 16'(bus.wb_rd), 16'd2);
      chk("b2b_data2", bus.wb_data, 16'h0003);
      mreg[1] = 16'h0007;
      mreg[2] = 16'h0003;
      @(negedge clk);
      chk("b2b_done_low", 16'(bus.done), 16'd0);
      bus.dbg_addr = 3'd1; #1;
      chk("dbg_r1", bus.dbg_data, 16'h0007);
      bus.dbg_addr = 3'd2; #1;
      chk("dbg_r2", bus.dbg_data, 16'h0003);

      run(16'h0650, 1'b0);
      chk("add_r3", bus.wb_data, 16'h000A);
      run(16'h1850, 1'b0);
      chk("sub_r4", bus.wb_data, 16'hFFFC);

      // Divide by R0: flag set, no write, then clear
      run(16'h4A40, 1'b0);
      chk("div0_set", 16'(bus.div0), 16'd1);
      chk("div0_r5", bus.dbg_data, 16'h0000);
      bus.div0_clr = 1'b1;
      @(posedge clk); #1;
      bus.div0_clr = 1'b0;
      mdiv0 = 1'b0;
      @(negedge clk);
      chk("div0_clr", 16'(bus.div0), 16'd0);
      run(16'h4A40, 1'b1);
      chk("div0_set_wins", 16'(bus.div0), 16'd1);
      bus.div0_clr = 1'b1;
      @(posedge clk); #1;
      bus.div0_clr = 1'b0;
      mdiv0 = 1'b0;
      @(negedge clk);
      chk("div0_clr2", 16'(bus.div0), 16'd0);

      // instr_valid held through EXEC: second instruction waits for IDLE
      ia = 16'h0C50;
      ib = 16'h2F88;
      bus.instr       = ia;
      bus.instr_valid = 1'b1;
      @(posedge clk); #1;
      bus.instr = ib;
      @(negedge clk);
      chk("hold_ex_ready", 16'(bus.instr_ready), 16'd0);
      chk("hold_a_op1", bus.alu_op1, mreg[1]);
      ra = alu_ref(OP_ADD, mreg[1], mreg[2]);
      mreg[6] = ra;
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_a_done", 16'(bus.done), 16'd1);
      chk("hold_a_rd", 16'(bus.wb_rd), 16'd6);
      chk("hold_a_data", bus.wb_data, ra);
      chk("hold_idle_ready", 16'(bus.instr_ready), 16'd1);
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("hold_b_ready", 16'(bus.instr_ready), 16'd0);
      chk("hold_b_done", 16'(bus.done), 16'd0);
      chk("hold_b_operator", 16'(bus.alu_operator), 16'(OP_MULT));
      chk("hold_b_op1", bus.alu_op1, mreg[6]);
      chk("hold_b_op2", bus.alu_op2, mreg[1]);
      rb = alu_ref(OP_MULT, mreg[6], mreg[1]);
      mreg[7] = rb;
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_b_wb_done", 16'(bus.done), 16'd1);
      chk("hold_b_wb_rd", 16'(bus.wb_rd), 16'd7);
      chk("hold_b_wb_data", bus.wb_data, rb);
      @(negedge clk);
      chk("hold_once", 16'(bus.done), 16'd0);
      chk("hold_ready_after", 16'(bus.instr_ready), 16'd1);

      // Reset during EXEC aborts the ADD into R5
      bus.instr       = 16'h0A50;
      bus.instr_valid = 1'b1;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      mdiv0 = 1'b0;
      @(negedge clk);
      chk_reset_outputs();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_done", 16'(bus.done), 16'd0);
      chk("abort_ready", 16'(bus.instr_ready), 16'd1);
      chk_regs("abort_reg");

      // Random stream: seed registers, then mixed LOADI/ALU instructions
      for (int i = 1; i < 8; i++)
         run({1'b1, 3'(i), 4'($urandom), 8'($urandom)}, 1'b0);
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) == 0)
            run({1'b1, 3'($urandom), 4'($urandom), 8'($urandom)}, 1'b0);
         else
            run({1'b0, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)},
                1'($urandom_range(0, 3) == 0));
      end
      chk_regs("final_reg");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
